// File: rtl/switch_sync_debounce.sv
// Synchronises and debounces a bank of slide switches, producing settled levels
// plus one-cycle rise/fall strobes for the downstream pin-mux logic.
module switch_sync_debounce #(
    parameter int                WIDTH        = 16,
    parameter int                SYNC_STAGES  = 2,
    parameter int                STABLE_TICKS = 256,
    parameter logic [WIDTH-1:0]  RESET_VALUE  = '0
) (
    input  logic             clock,
    input  logic             nres,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] switch_raw,
    output logic [WIDTH-1:0] switch_db,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed,
    output logic             settled
);

    localparam int             CW   = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0]  LAST = CW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_out;

    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] db_q, db_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q, changed_d;
    logic             settled_q, settled_d;

    // The synchroniser runs every edge; sample_en only gates the debounce.
    always_ff @(posedge clock or negedge nres) begin
        if (!nres) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= RESET_VALUE;
        end else begin
            sync_q[0] <= switch_raw;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        db_d      = db_q;
        rise_d    = '0;
        fall_d    = '0;
        settled_d = (sync_out == db_q);
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_q[i] != '0) settled_d = 1'b0;
            if (sample_en) begin
                if (sync_out[i] == db_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == LAST) begin
                    db_d[i]   = sync_out[i];
                    cnt_d[i]  = '0;
                    rise_d[i] = sync_out[i];
                    fall_d[i] = ~sync_out[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clock or negedge nres) begin
        if (!nres) begin
            // NOTE: the counters are plain flops (not a RAM), so clearing them all on reset is legal.
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            db_q      <= RESET_VALUE;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            settled_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
            db_q      <= db_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            settled_q <= settled_d;
        end
    end

    assign switch_db = db_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign changed   = changed_q;
    assign settled   = settled_q;

endmodule

// File: tb/tb_switch_sync_debounce.sv
// Bench for switch_sync_debounce: a run-length model checked every cycle, plus
// literal expectations at the hand-counted edges of each directed scenario.
module tb_switch_sync_debounce;

    localparam int               WIDTH        = 4;
    localparam int               SYNC_STAGES  = 2;
    localparam int               STABLE_TICKS = 8;
    localparam logic [WIDTH-1:0] RESET_VALUE  = 4'b1000;

    logic             clock = 1'b0;
    logic             nres;
    logic             sample_en;
    logic [WIDTH-1:0] switch_raw;
    logic [WIDTH-1:0] switch_db, rise, fall;
    logic             changed, settled;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    switch_sync_debounce #(
        .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES),
        .STABLE_TICKS(STABLE_TICKS), .RESET_VALUE(RESET_VALUE)
    ) dut (
        .clock(clock), .nres(nres), .sample_en(sample_en), .switch_raw(switch_raw),
        .switch_db(switch_db), .rise(rise), .fall(fall),
        .changed(changed), .settled(settled)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: raw history gives the synchronised view; each bit tracks how many
    // consecutive enabled samples disagreed with its accepted level.
    logic [WIDTH-1:0] hist[$];
    logic [WIDTH-1:0] m_db, m_rise, m_fall;
    logic             m_changed, m_settled;
    int               m_run [WIDTH];

    always @(posedge clock or negedge nres) begin
        if (!nres) begin
            hist.delete();
            for (int k = 0; k < SYNC_STAGES; k++) hist.push_back(RESET_VALUE);
            m_db = RESET_VALUE; m_rise = '0; m_fall = '0;
            m_changed = 1'b0; m_settled = 1'b1;
            for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
        end else begin
            logic [WIDTH-1:0] seen;
            seen      = hist[SYNC_STAGES-1];
            m_settled = (seen == m_db);
            for (int i = 0; i < WIDTH; i++) if (m_run[i] != 0) m_settled = 1'b0;
            m_rise = '0; m_fall = '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (sample_en) begin
                    if (seen[i] != m_db[i]) begin
                        m_run[i]++;
                        if (m_run[i] == STABLE_TICKS) begin
                            m_db[i] = seen[i];
                            if (seen[i]) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
            m_changed = (m_rise != 0) || (m_fall != 0);
            hist.push_front(switch_raw);
            void'(hist.pop_back());
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            check("m_db", switch_db, m_db);
            check("m_rise", rise, m_rise);
            check("m_fall", fall, m_fall);
            check("m_changed", changed, m_changed);
            check("m_settled", settled, m_settled);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int nfall;
        nres = 1'b0; sample_en = 1'b1; switch_raw = 4'b0101;
        #1 cmp_en = 1'b1;
        #12;
        check("t1_reset_db", switch_db, 4'b1000);
        check("t1_reset_strobes", {rise, fall}, 8'h00);
        check("t1_reset_changed", changed, 1'b0);
        check("t1_reset_settled", settled, 1'b1);
        @(posedge clock); #2 nres = 1'b1;
        tick(9);  check("t1_rise_e9", rise, 4'b0000);
        tick(1);  check("t1_rise_e10", rise, 4'b0101);
                  check("t1_fall_e10", fall, 4'b1000);
                  check("t1_db_e10", switch_db, 4'b0101);
        tick(3);

        // Clean rising edge on bit 1
        switch_raw = 4'b0111;
        tick(2);  check("t2_settled_e2", settled, 1'b1);
        tick(1);  check("t2_settled_e3", settled, 1'b0);
        tick(6);  check("t2_db_e9", switch_db, 4'b0101);
        tick(1);  check("t2_db_e10", switch_db, 4'b0111);
                  check("t2_rise_e10", rise, 4'b0010);
                  check("t2_changed_e10", changed, 1'b1);
        tick(1);  check("t2_changed_e11", changed, 1'b0);
                  check("t2_settled_e11", settled, 1'b1);

        // Bounce on bit 3: high 5, low 2, then high for good
        switch_raw = 4'b1111; tick(5);
        switch_raw = 4'b0111; tick(2);
        switch_raw = 4'b1111;
        tick(9);  check("t3_db_e9", switch_db, 4'b0111);
        tick(1);  check("t3_db_e10", switch_db, 4'b1111);
                  check("t3_rise_e10", rise, 4'b1000);
        tick(2);

        // Simultaneous rise on bit 2 and fall on bit 3
        switch_raw = 4'b1011; tick(12);
        check("t4_prep_db", switch_db, 4'b1011);
        switch_raw = 4'b0111;
        tick(10); check("t4_rise", rise, 4'b0100);
                  check("t4_fall", fall, 4'b1000);
                  check("t4_changed", changed, 1'b1);
        tick(1);  check("t4_changed_after", changed, 1'b0);
                  check("t4_db", switch_db, 4'b0111);

        // Gated sampling: enable one clock in four
        switch_raw = 4'b0110;
        nfall = 0;
        for (int c = 0; c < 48; c++) begin
            sample_en = (c % 4 == 0);
            tick(1);
            if (c == 30) check("t5_db_early", switch_db, 4'b0111);
            if (fall[0]) nfall++;
        end
        check("t5_fall_count", nfall, 1);
        check("t5_db", switch_db, 4'b0110);
        sample_en = 1'b1;
        tick(2);

        // Reset in the middle of a count
        switch_raw = 4'b0111;
        tick(7);
        nres = 1'b0;
        #1;
        check("t6_reset_db", switch_db, 4'b1000);
        check("t6_reset_settled", settled, 1'b1);
        tick(2);
        nres = 1'b1;
        tick(9);  check("t6_db_e9", switch_db, 4'b1000);
                  check("t6_rise_e9", rise, 4'b0000);
        tick(1);  check("t6_db_e10", switch_db, 4'b0111);
                  check("t6_rise_e10", rise, 4'b0111);
                  check("t6_fall_e10", fall, 4'b1000);
        tick(3);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
